// File: rtl/rgb2gray_controller.sv
// Sequencer for the rgb2gray datapath: accepts one RGB word, steps the shared
// multiplier over R, G and B, loads the gray register, then holds the output
// handshake until the consumer takes the result. Counts pixels per frame.
module rgb2gray_controller #(
  parameter int unsigned CNT_W = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] numPixels_i,
  input  logic             inValid_i,
  output logic             inReady_o,
  output logic             outValid_o,
  input  logic             outReady_i,
  output logic             ldRGB_o,
  output logic             clrAcc_o,
  output logic             ldAcc_o,
  output logic [1:0]       selCh_o,
  output logic             ldGray_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] pixCnt_o
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitIn,
    StMacR,
    StMacG,
    StMacB,
    StWr,
    StOut,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] size_q, size_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  // Terminal compare on the incremented count, so a frame of 2^CNT_W-1 never wraps.
  assign cnt_inc = pix_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // State, frame size and pixel counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      size_q    <= '0;
      pix_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

  // Next-state and strobe decode; clear_i overrides everything and silences strobes.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    pix_cnt_d  = pix_cnt_q;
    inReady_o  = 1'b0;
    outValid_o = 1'b0;
    ldRGB_o    = 1'b0;
    clrAcc_o   = 1'b0;
    ldAcc_o    = 1'b0;
    selCh_o    = 2'd0;
    ldGray_o   = 1'b0;
    done_o     = 1'b0;

    if (clear_i) begin
      state_d   = StIdle;
      pix_cnt_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            pix_cnt_d = '0;
            if (numPixels_i == '0) begin
              state_d = StDone;
            end else begin
              size_d  = numPixels_i;
              state_d = StWaitIn;
            end
          end
        end
        StWaitIn: begin
          inReady_o = 1'b1;
          if (inValid_i) begin
            // Mealy: capture the word and zero the accumulator in the handshake cycle.
            ldRGB_o  = 1'b1;
            clrAcc_o = 1'b1;
            state_d  = StMacR;
          end
        end
        StMacR: begin
          selCh_o = 2'd0;
          ldAcc_o = 1'b1;
          state_d = StMacG;
        end
        StMacG: begin
          selCh_o = 2'd1;
          ldAcc_o = 1'b1;
          state_d = StMacB;
        end
        StMacB: begin
          selCh_o = 2'd2;
          ldAcc_o = 1'b1;
          state_d = StWr;
        end
        StWr: begin
          ldGray_o = 1'b1;
          state_d  = StOut;
        end
        StOut: begin
          outValid_o = 1'b1;
          if (outReady_i) begin
            pix_cnt_d = cnt_inc;
            state_d   = (cnt_inc == size_q) ? StDone : StWaitIn;
          end
        end
        StDone: begin
          done_o  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign pixCnt_o = pix_cnt_q;

endmodule
